// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

  // Returned in place of an instruction whenever a fetch is rejected.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One in-flight fetch as it travels down the read pipeline.
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } fetch_entry_t;

  // Bits held per response in the FIFO. The valid flag is implied by occupancy.
  localparam int PAYLOAD_W = $bits(fetch_entry_t) - 1;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response handshake between the fetch unit (master) and the
// instruction memory responder (slave).
interface imem_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_addr, resp_err
  );
endinterface

// File: rtl/imem_fetch_responder_resp_fifo.sv
// Synchronous show-ahead FIFO holding completed fetch responses until the
// consumer takes them. Flush empties it in one edge and overrides push/pop.
module imem_resp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Entry storage: written on push, never reset.
  // NOTE: storage arrays carry no reset; occupancy/pointers alone decide what
  // is valid, which keeps the array free of reset fan-out.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush returns to empty.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = store[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory responder: accepts word fetches, reads the memory at the
// accepting edge, carries the result down a fixed-latency pipeline into a
// response FIFO, and throttles new requests with an outstanding-request credit.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  imem_fetch_responder_if.slave bus,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [31:0]          prog_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    mem [DEPTH_WORDS];
  logic           accept;
  logic           pop;
  logic           addr_err;
  fetch_entry_t   rd_entry;
  fetch_entry_t   fifo_in;
  logic [CW-1:0]  inflight_cnt;
  logic [CW-1:0]  fifo_cnt;
  logic [CW:0]    occupancy;
  logic           fifo_empty;
  logic [PAYLOAD_W-1:0] fifo_head;

  // Program-load port; contents survive reset so a loaded image outlives a core reset.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // A request is accepted only while credit remains and no flush is in progress.
  assign occupancy     = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign bus.req_ready = !reset && !bus.flush && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.resp_valid && bus.resp_ready && !bus.flush;

  assign addr_err = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[31:AW+2]);

  // Decode and read the addressed word; a same-edge program write is not seen.
  // NOTE: every field gets a default first so no path through the block can
  // infer a latch.
  always_comb begin
    rd_entry       = '0;
    rd_entry.valid = accept;
    rd_entry.addr  = bus.req_addr;
    rd_entry.err   = addr_err;
    rd_entry.data  = addr_err ? NOP_INSTR : mem[bus.req_addr[AW+1:2]];
  end

  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign fifo_in = rd_entry;
    end else begin : g_pipe
      fetch_entry_t pipe [LATENCY-1];

      // Fixed-delay shift register; advances every cycle, flush drops its contents.
      always_ff @(posedge clock or posedge reset) begin
        if (reset || bus.flush) begin
          for (int i = 0; i < LATENCY-1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= rd_entry;
          for (int i = 1; i < LATENCY-1; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign fifo_in = pipe[LATENCY-2];
    end
  endgenerate

  // Requests in the pipeline, not yet in the FIFO; together with fifo_cnt this
  // is the credit usage, so the FIFO always has room for the final stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_cnt <= '0;
    end else if (bus.flush) begin
      inflight_cnt <= '0;
    end else begin
      inflight_cnt <= inflight_cnt + CW'(accept) - CW'(fifo_in.valid);
    end
  end

  imem_resp_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_in.valid),
    .push_data ({fifo_in.addr, fifo_in.data, fifo_in.err}),
    .pop       (pop),
    .flush     (bus.flush),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Response fields are forced to zero when nothing is pending, hiding stale storage.
  assign bus.resp_valid = !fifo_empty;
  assign {bus.resp_addr, bus.resp_data, bus.resp_err} = fifo_empty ? '0 : fifo_head;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: a negedge monitor keeps a
// scoreboard of accepted fetches and checks every response, its timing and
// the request credit; scenario tasks add their own targeted checks.
module tb_imem_fetch_responder;
  import imem_pkg::*;

  localparam int LAT = 2;
  localparam int FD  = 4;
  localparam int DW  = 256;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          vis;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;

  logic [31:0] model [DW];
  exp_t        q [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  imem_fetch_responder_if bus ();

  imem_fetch_responder #(
    .DEPTH_WORDS (DW),
    .LATENCY     (LAT),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Scoreboard monitor: inputs are stable at the falling edge, so what is seen
  // here is exactly what the next rising edge acts on.
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL in_reset: resp_valid=%b req_ready=%b, required 0 0",
                 bus.resp_valid, bus.req_ready);
      end
    end else begin
      logic exp_ready;
      logic exp_valid;
      exp_ready = !bus.flush && (q.size() < FD);
      exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
      n_checks++;
      if (bus.req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL req_ready @%0d: got %b, required %b", cyc, bus.req_ready, exp_ready);
      end
      n_checks++;
      if (bus.resp_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL resp_valid @%0d: got %b, required %b", cyc, bus.resp_valid, exp_valid);
      end
      if (exp_valid && bus.resp_valid === 1'b1) begin
        n_checks++;
        if (bus.resp_data !== q[0].data || bus.resp_addr !== q[0].addr ||
            bus.resp_err !== q[0].err) begin
          n_fail++;
          $display("FAIL resp @%0d: got data=%h addr=%h err=%b, required data=%h addr=%h err=%b",
                   cyc, bus.resp_data, bus.resp_addr, bus.resp_err,
                   q[0].data, q[0].addr, q[0].err);
        end
      end
      if (bus.flush) begin
        q.delete();
      end else begin
        if (bus.resp_valid === 1'b1 && bus.resp_ready && q.size() > 0) void'(q.pop_front());
        if (bus.req_valid && bus.req_ready === 1'b1) begin
          exp_t e;
          logic [31:0] a;
          a      = bus.req_addr;
          e.addr = a;
          e.err  = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DW));
          e.data = e.err ? 32'h0000_0013 : model[a[9:2]];
          e.vis  = cyc + LAT;
          q.push_back(e);
        end
      end
    end
    if (prog_we) model[prog_addr] = prog_data;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    prog_we       = 1'b0;
  endtask

  task automatic drain();
    idle_bus();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    step();
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 ||
        bus.resp_addr !== 32'h0 || bus.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h addr=%h err=%b, required all 0",
               bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_addr, bus.resp_err);
    end
    step();
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 1", bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs = '{32'h0, 32'h4, 32'h8};
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = addrs[i];
      step();
    end
    idle_bus();
    // Third accept edge pops 0xA0 and pushes 0xA1 at the head.
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hA1 || bus.resp_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL b2b_head: valid=%b data=%h addr=%h, required 1 000000a1 00000004",
               bus.resp_valid, bus.resp_data, bus.resp_addr);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'((i % 4) * 4);
      if (bus.req_ready === 1'b1) accepted++;
      step();
    end
    idle_bus();
    n_checks++;
    if (accepted != FD || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_limit: accepted=%0d ready=%b, required %0d 0",
               accepted, bus.req_ready, FD);
    end
    bus.resp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_pop: got %b, required 0", bus.req_ready);
    end
    step();
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_pop: got %b, required 1", bus.req_ready);
    end
    drain();
  endtask

  task automatic test_errors();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h6;
    step();
    bus.req_addr   = 32'h400;
    step();
    bus.req_valid  = 1'b0;
    step();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_data !== NOP_INSTR ||
        bus.resp_addr !== 32'h400) begin
      n_fail++;
      $display("FAIL out_of_range: valid=%b err=%b data=%h addr=%h, required 1 1 00000013 00000400",
               bus.resp_valid, bus.resp_err, bus.resp_data, bus.resp_addr);
    end
    drain();
  endtask

  task automatic test_flush();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(i * 4);
      step();
    end
    bus.flush    = 1'b1;
    bus.req_addr = 32'hC;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_during_flush: got %b, required 0", bus.req_ready);
    end
    step();
    idle_bus();
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_flush: valid=%b ready=%b, required 0 1", bus.resp_valid, bus.req_ready);
    end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_leak: resp_valid=%b, required 0", bus.resp_valid);
    end
  endtask

  task automatic test_prog_collision();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h14;
    prog_we        = 1'b1;
    prog_addr      = 8'd5;
    prog_data      = 32'hDEAD;
    step();
    prog_we        = 1'b0;
    step();
    bus.req_valid  = 1'b0;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h55) begin
      n_fail++;
      $display("FAIL old_value: valid=%b data=%h, required 1 00000055", bus.resp_valid, bus.resp_data);
    end
    step();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL new_value: valid=%b data=%h, required 1 0000dead", bus.resp_valid, bus.resp_data);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0;
    step();
    bus.req_addr   = 32'h4;
    step();
    idle_bus();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h ready=%b, required 0 00000000 0",
               bus.resp_valid, bus.resp_data, bus.req_ready);
    end
    step();
    step();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_after_reset: resp_valid=%b, required 0", bus.resp_valid);
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h14;
    step();
    bus.req_valid = 1'b0;
    step();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL mem_survives_reset: valid=%b data=%h, required 1 0000dead",
               bus.resp_valid, bus.resp_data);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < DW; i++) model[i] = '0;
    reset          = 1'b1;
    bus.resp_ready = 1'b0;
    prog_addr      = '0;
    prog_data      = '0;
    idle_bus();

    test_reset();
    load_word(8'd0, 32'hA0);
    load_word(8'd1, 32'hA1);
    load_word(8'd2, 32'hA2);
    load_word(8'd3, 32'hA3);
    load_word(8'd5, 32'h55);
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_flush();
    test_prog_collision();
    test_reset_midop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Memory-side responder for the instruction-fetch interface: accepts fetch requests (word address from the fetch unit) and returns the instruction word after a fixed latency.
- Replaces the combinational instruction ROM with a pipelined, flow-controlled, in-order responder and a response FIFO.
- Includes a program-load write port so test benches and the boot loader can fill memory at run time.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words; power of 2; AW = log2(DEPTH_WORDS).
- LATENCY, 2, edges from request acceptance to response visibility; legal range 1..4.
- FIFO_DEPTH, 4, maximum outstanding requests (in-flight plus buffered); power of 2; must be >= LATENCY.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address of the instruction.
- flush  in  1  discard all outstanding requests and responses (branch redirect).
- resp_valid  out  1  response at FIFO head.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  32  instruction word (NOP 0x00000013 on error).
- resp_addr  out  32  echo of the request's req_addr.
- resp_err  out  1  misaligned or out-of-range request.
- prog_we  in  1  program-load write enable.
- prog_addr  in  AW  word index to write.
- prog_data  in  32  word to write.

Behaviour:
- Reset is asynchronous and active-high; clock is clock. While reset is high: req_ready=0, resp_valid=0, resp_data=0, resp_addr=0, resp_err=0, all pipeline valids cleared, FIFO emptied, counters cleared.
- Memory contents are NOT cleared by reset, so a loaded program survives a core reset. Initial contents are zero.
- Acceptance occurs at a rising edge with req_valid && req_ready. The memory read happens at that edge (data captured into stage 0).
- req_ready = !flush && (inflight_cnt + fifo_cnt) < FIFO_DEPTH. Both counts are registered. req_ready has no combinational path from resp_ready; a pop frees a credit the following cycle.
- Timing: for a request accepted at edge k with an empty FIFO, resp_valid=1 in the cycle after edge k+LATENCY-1. With LATENCY=1, the response is visible the cycle right after acceptance.
- Pipeline: LATENCY-1 shift stages {valid, addr, data, err} advance every cycle unconditionally. The final stage writes into the FIFO. Credits guarantee the FIFO is never full on write.
- The FIFO is show-ahead: resp_* reflect the head entry. The head is popped at a rising edge with resp_valid && resp_ready. Responses are strictly in request order.
- Stability: while resp_valid=1 && resp_ready=0, resp_data, resp_addr and resp_err hold stable.
- Error handling:
  - req_addr[1:0] != 0 → err=1, data=NOP.
  - req_addr[31:2] >= DEPTH_WORDS → err=1, data=NOP.
  - Otherwise data = mem[req_addr[AW+1:2]], err=0.
- Program write: prog_we writes mem[prog_addr] at the rising edge. A same-edge read of the same word returns the OLD value. Writes are independent of flush and stall.
- Flush at a rising edge:
  - clears all pipeline valids and the FIFO;
  - inflight_cnt and fifo_cnt go to 0;
  - no request is accepted that cycle (req_ready=0);
  - any pop in the same cycle is ignored (the entry is discarded anyway);
  - resp_valid=0 and req_ready=1 in the next cycle.
- Simultaneous accept and pop in one cycle: the counts update consistently (the net occupancy change may be zero).
- Reset asserted mid-operation: outputs take reset values immediately (asynchronously); no stale response appears after reset deasserts.

Decomposition:
- Package imem_pkg:
  - constant NOP_INSTR = 32'h00000013;
  - typedef fetch_entry_t {valid, addr[31:0], data[31:0], err}.
- Sub-module imem_resp_fifo: synchronous show-ahead FIFO with push, pop, flush and count outputs, parameterised on width and depth.
- Top level holds the memory array, the LATENCY pipeline, the credit counter and the error decode.

Test Plan:
- Load words 0..3 = 0xA0,0xA1,0xA2,0xA3; with resp_ready=1, request 0x0, 0x4, 0x8 back-to-back (LATENCY=2) → resp_valid in the cycles after edges 1, 2, 3 with data 0xA0, 0xA1, 0xA2 and resp_addr echoed, err=0.
- With resp_ready=0, drive req_valid continuously for 6 cycles → exactly 4 accepted and req_ready=0 thereafter. Raise resp_ready → 4 in-order responses, and req_ready returns 1 the cycle after the first pop.
- Request 0x6 → resp_err=1, resp_data=0x00000013, resp_addr=0x6. Request 0x400 (DEPTH_WORDS=256) → resp_err=1, NOP.
- Accept 3 requests, then pulse flush with a new req_valid in the same cycle → that request is not accepted, no responses emerge, and resp_valid=0 and req_ready=1 the next cycle.
- Write prog_addr=5 with 0xDEAD on the same edge a request for 0x14 is accepted → response = old value. A subsequent request for 0x14 → 0xDEAD.
- Assert reset with 2 requests in flight → resp_valid=0 immediately. After release, no stale response appears, and memory word 5 still reads 0xDEAD.
